// File: rtl/waveform_player_mc.sv
`default_nettype none
// ============================================================================
// waveform_player_mc : multi-channel square-wave player, Avalon-MM registers in, Avalon-ST per channel out
// Revision: 1.0
// ============================================================================
module waveform_player_mc #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int LEN_WIDTH    = 32
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic [2:0]                         address,
  input  logic                               write,
  input  logic [31:0]                        writedata,
  input  logic                               read,
  output logic [31:0]                        readdata,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] audio_data,
  output logic [NUM_CHANNELS-1:0]            audio_valid,
  input  logic [NUM_CHANNELS-1:0]            audio_ready
);

  localparam int AW = DATA_WIDTH - 1;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t                            state_q, state_d;
  logic                              run_q, run_d, oneshot_q, oneshot_d;
  logic [LEN_WIDTH-1:0]              hp_q, hp_d, burst_q, burst_d;
  logic [AW-1:0]                     amp_q, amp_d;
  logic [NUM_CHANNELS-1:0]           chen_q, chen_d;
  logic [LEN_WIDTH-1:0]              hp_sh_q, hp_sh_d, burst_sh_q, burst_sh_d;
  logic [AW-1:0]                     amp_sh_q, amp_sh_d;
  logic [NUM_CHANNELS-1:0]           en_sh_q, en_sh_d, taken_q, taken_d;
  logic [LEN_WIDTH-1:0]              phase_q, phase_d, count_q, count_d;
  logic                              pol_q, pol_d, done_q, done_d, stop_q, stop_d;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] hold_q;
  logic [31:0]                       readdata_q, readdata_d;

  logic [DATA_WIDTH-1:0]   samp_pos, samp_neg, samp;
  logic [NUM_CHANNELS-1:0] accept;
  logic [LEN_WIDTH-1:0]    hp_eff, phase_inc;
  logic                    commit, ctrl_wr, busy;

  assign busy     = (state_q == S_STREAM);
  assign samp_pos = {1'b0, amp_sh_q};
  // Negating {0,amp} keeps the output clear of the most-negative code.
  assign samp_neg = DATA_WIDTH'(0) - {1'b0, amp_sh_q};
  assign samp     = pol_q ? samp_pos : samp_neg;
  assign ctrl_wr  = write && (address == 3'd0);
  assign hp_eff   = (hp_sh_q == '0) ? LEN_WIDTH'(1) : hp_sh_q;
  assign phase_inc = phase_q + LEN_WIDTH'(1);
  assign readdata = readdata_q;

  // In IDLE the last streamed data is held; before any stream it is zero.
  always_comb begin
    audio_valid = '0;
    audio_data  = hold_q;
    if (busy) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        audio_valid[c] = en_sh_q[c] & ~taken_q[c];
        audio_data[c*DATA_WIDTH +: DATA_WIDTH] = en_sh_q[c] ? samp : '0;
      end
    end
  end

  assign accept = audio_valid & audio_ready;
  assign commit = busy && ((taken_q | accept | ~en_sh_q) == {NUM_CHANNELS{1'b1}});

  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    oneshot_d  = oneshot_q;
    hp_d       = hp_q;
    amp_d      = amp_q;
    burst_d    = burst_q;
    chen_d     = chen_q;
    hp_sh_d    = hp_sh_q;
    amp_sh_d   = amp_sh_q;
    en_sh_d    = en_sh_q;
    burst_sh_d = burst_sh_q;
    taken_d    = taken_q | accept;
    phase_d    = phase_q;
    count_d    = count_q;
    pol_d      = pol_q;
    done_d     = done_q;
    stop_d     = stop_q;
    readdata_d = '0;

    if (write) begin
      case (address)
        3'd0: begin
          run_d     = writedata[0];
          oneshot_d = writedata[1];
        end
        3'd1:    hp_d    = LEN_WIDTH'(writedata);
        3'd2:    amp_d   = AW'(writedata);
        3'd3:    burst_d = LEN_WIDTH'(writedata);
        3'd4:    chen_d  = NUM_CHANNELS'(writedata);
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && writedata[0]) begin
          phase_d    = '0;
          count_d    = '0;
          done_d     = 1'b0;
          pol_d      = 1'b1;
          taken_d    = '0;
          stop_d     = 1'b0;
          hp_sh_d    = hp_q;
          amp_sh_d   = amp_q;
          en_sh_d    = chen_q;
          burst_sh_d = burst_q;
          if (writedata[1] && (burst_q == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (ctrl_wr && !writedata[0]) begin
          stop_d = 1'b1;
        end
        if (commit) begin
          taken_d  = '0;
          count_d  = count_q + LEN_WIDTH'(1);
          hp_sh_d  = hp_q;
          amp_sh_d = amp_q;
          en_sh_d  = chen_q;
          if (phase_inc >= hp_eff) begin
            phase_d = '0;
            pol_d   = ~pol_q;
          end else begin
            phase_d = phase_inc;
          end
          if (oneshot_q && (count_d == burst_sh_q)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
          if (stop_q || (ctrl_wr && !writedata[0])) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (read) begin
      case (address)
        3'd0:    readdata_d = {30'd0, oneshot_q, run_q};
        3'd1:    readdata_d = 32'(hp_q);
        3'd2:    readdata_d = 32'(amp_q);
        3'd3:    readdata_d = 32'(burst_q);
        3'd4:    readdata_d = 32'(chen_q);
        3'd5:    readdata_d = {29'd0, pol_q, done_q, busy};
        3'd6:    readdata_d = 32'(count_q);
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      run_q      <= 1'b0;
      oneshot_q  <= 1'b0;
      hp_q       <= LEN_WIDTH'(24);
      amp_q      <= '0;
      burst_q    <= '0;
      chen_q     <= '1;
      hp_sh_q    <= LEN_WIDTH'(24);
      amp_sh_q   <= '0;
      en_sh_q    <= '1;
      burst_sh_q <= '0;
      taken_q    <= '0;
      phase_q    <= '0;
      count_q    <= '0;
      pol_q      <= 1'b0;
      done_q     <= 1'b0;
      stop_q     <= 1'b0;
      hold_q     <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      oneshot_q  <= oneshot_d;
      hp_q       <= hp_d;
      amp_q      <= amp_d;
      burst_q    <= burst_d;
      chen_q     <= chen_d;
      hp_sh_q    <= hp_sh_d;
      amp_sh_q   <= amp_sh_d;
      en_sh_q    <= en_sh_d;
      burst_sh_q <= burst_sh_d;
      taken_q    <= taken_d;
      phase_q    <= phase_d;
      count_q    <= count_d;
      pol_q      <= pol_d;
      done_q     <= done_d;
      stop_q     <= stop_d;
      hold_q     <= audio_data;
      readdata_q <= readdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_waveform_player_mc.sv
`default_nettype none
// ============================================================================
// tb_waveform_player_mc : scoreboard bench for the two-channel waveform player
// Revision: 1.0
// ============================================================================
module tb_waveform_player_mc;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic [31:0] audio_data;
  logic [1:0]  audio_valid;
  logic [1:0]  audio_ready;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb0[$];
  logic [15:0] sb1[$];

  waveform_player_mc #(.NUM_CHANNELS(2), .DATA_WIDTH(16), .LEN_WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .audio_data(audio_data), .audio_valid(audio_valid), .audio_ready(audio_ready)
  );

  always #5 clock = ~clock;

  // One clock: scoreboard any handshake visible now, then advance past the edge.
  task automatic cyc();
    logic [15:0] e;
    if (reset_n) begin
      if (audio_valid[0] && audio_ready[0]) begin
        checks++;
        if (sb0.size() == 0) begin
          errors++;
          $display("FAIL sb_ch0 unexpected sample got %h required none", audio_data[15:0]);
        end else begin
          e = sb0.pop_front();
          if (audio_data[15:0] !== e) begin
            errors++;
            $display("FAIL sb_ch0 got %h required %h", audio_data[15:0], e);
          end
        end
      end
      if (audio_valid[1] && audio_ready[1]) begin
        checks++;
        if (sb1.size() == 0) begin
          errors++;
          $display("FAIL sb_ch1 unexpected sample got %h required none", audio_data[31:16]);
        end else begin
          e = sb1.pop_front();
          if (audio_data[31:16] !== e) begin
            errors++;
            $display("FAIL sb_ch1 got %h required %h", audio_data[31:16], e);
          end
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    cyc();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    cyc();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic push_wave(input int first, input int n, input int hp,
                           input logic [15:0] amp, input bit ch0, input bit ch1);
    logic [15:0] v;
    for (int k = first; k < first + n; k++) begin
      v = (((k / hp) % 2) == 0) ? amp : (16'h0000 - amp);
      if (ch0) sb0.push_back(v);
      if (ch1) sb1.push_back(v);
    end
  endtask

  task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    checks++;
    if (d !== exp) begin
      errors++;
      $display("FAIL %s got %h required %h", name, d, exp);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb0.size() != 0 || sb1.size() != 0) begin
      errors++;
      $display("FAIL %s_drained got %0d/%0d pending required 0/0", name, sb0.size(), sb1.size());
    end
    sb0.delete();
    sb1.delete();
  endtask

  task automatic test_reset();
    logic [31:0] exp [8];
    exp = '{32'd0, 32'd24, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0};
    reset_n = 1'b0;
    cyc(); cyc();
    checks++;
    if (audio_valid !== 2'b00 || audio_data !== 32'd0 || readdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%h r=%h required 0", audio_valid, audio_data, readdata);
    end
    reset_n = 1'b1;
    cyc();
    for (int a = 0; a < 8; a++) check_reg($sformatf("reset_reg%0d", a), 3'(a), exp[a]);
  endtask

  task automatic test_stream();
    audio_ready = 2'b11;
    bus_write(3'd1, 32'd3);
    bus_write(3'd2, 32'h1000);
    push_wave(0, 13, 3, 16'h1000, 1'b1, 1'b1);
    bus_write(3'd0, 32'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (audio_valid !== 2'b11) begin
        errors++;
        $display("FAIL stream_valid got %b required 11", audio_valid);
      end
      cyc();
    end
    bus_write(3'd0, 32'd1);  // restart attempt while busy must be ignored
    for (int i = 0; i < 7; i++) cyc();
    bus_write(3'd0, 32'd0);
    checks++;
    if (audio_valid !== 2'b00) begin
      errors++;
      $display("FAIL stream_stop_valid got %b required 00", audio_valid);
    end
    check_drained("stream");
    check_reg("stream_count", 3'd6, 32'd13);
  endtask

  task automatic test_oneshot();
    audio_ready = 2'b01;
    bus_write(3'd2, 32'h0123);
    bus_write(3'd3, 32'd5);
    push_wave(0, 5, 3, 16'h0123, 1'b1, 1'b1);
    bus_write(3'd0, 32'd3);
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (audio_valid !== 2'b10) begin
        errors++;
        $display("FAIL oneshot_wait_valid got %b required 10", audio_valid);
      end
    end
    audio_ready = 2'b11;
    for (int i = 0; i < 50 && (sb0.size() != 0 || sb1.size() != 0); i++) cyc();
    check_drained("oneshot");
    checks++;
    if (audio_valid !== 2'b00) begin
      errors++;
      $display("FAIL oneshot_idle_valid got %b required 00", audio_valid);
    end
    check_reg("oneshot_status", 3'd5, 32'b010);
    check_reg("oneshot_count", 3'd6, 32'd5);
  endtask

  task automatic test_stop_pending();
    audio_ready = 2'b01;
    push_wave(0, 1, 3, 16'h0123, 1'b1, 1'b1);
    bus_write(3'd0, 32'd1);
    cyc();                       // ch0 accepted, ch1 held off
    bus_write(3'd0, 32'd0);
    audio_ready = 2'b11;
    cyc();                       // ch1 delivers the held sample
    check_drained("stop");
    checks++;
    if (audio_valid !== 2'b00 || audio_data[31:16] !== 16'h0123) begin
      errors++;
      $display("FAIL stop_idle got v=%b d1=%h required 00/0123", audio_valid, audio_data[31:16]);
    end
    check_reg("stop_status", 3'd5, 32'b100);
    check_reg("stop_count", 3'd6, 32'd1);
  endtask

  task automatic test_chan_en();
    audio_ready = 2'b11;
    bus_write(3'd1, 32'd2);
    bus_write(3'd2, 32'h0200);
    push_wave(0, 4, 2, 16'h0200, 1'b1, 1'b0);
    push_wave(0, 8, 2, 16'h0200, 1'b0, 1'b1);
    bus_write(3'd0, 32'd1);
    cyc(); cyc();
    bus_write(3'd4, 32'd2);
    for (int s = 3; s < 7; s++) begin
      if (s >= 4) begin
        checks++;
        if (audio_valid !== 2'b10 || audio_data[15:0] !== 16'h0000) begin
          errors++;
          $display("FAIL chan_en_off got v=%b d0=%h required 10/0000", audio_valid, audio_data[15:0]);
        end
      end
      cyc();
    end
    bus_write(3'd0, 32'd0);
    check_drained("chan_en");
    bus_write(3'd4, 32'd3);
  endtask

  task automatic test_oneshot_zero();
    logic [31:0] d;
    audio_ready = 2'b11;
    bus_write(3'd3, 32'd0);
    bus_write(3'd0, 32'd3);
    bus_read(3'd5, d);
    checks++;
    if (d[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL zero_burst_status got %b required 10", d[1:0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (audio_valid !== 2'b00) begin
        errors++;
        $display("FAIL zero_burst_valid got %b required 00", audio_valid);
      end
      cyc();
    end
    check_reg("zero_burst_count", 3'd6, 32'd0);
  endtask

  task automatic test_reset_mid();
    audio_ready = 2'b11;
    bus_write(3'd2, 32'h7FFF);
    bus_write(3'd3, 32'd20);
    push_wave(0, 4, 2, 16'h7FFF, 1'b1, 1'b1);
    push_wave(4, 1, 2, 16'h7FFF, 1'b1, 1'b0);
    bus_write(3'd0, 32'd3);
    for (int i = 0; i < 4; i++) cyc();
    audio_ready = 2'b01;
    cyc();                       // ch0 takes sample 4, ch1 still pending
    reset_n = 1'b0;
    cyc();
    checks++;
    if (audio_valid !== 2'b00 || audio_data !== 32'd0) begin
      errors++;
      $display("FAIL midreset_outputs got v=%b d=%h required 0", audio_valid, audio_data);
    end
    reset_n = 1'b1;
    check_drained("midreset");
    check_reg("midreset_ctrl", 3'd0, 32'd0);
    check_reg("midreset_hp", 3'd1, 32'd24);
    check_reg("midreset_amp", 3'd2, 32'd0);
    check_reg("midreset_burst", 3'd3, 32'd0);
    check_reg("midreset_status", 3'd5, 32'd0);
    check_reg("midreset_count", 3'd6, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; address = 3'd0; write = 1'b0; writedata = 32'd0;
    read = 1'b0; audio_ready = 2'b00;
    #1;
    test_reset();
    test_stream();
    test_oneshot();
    test_stop_pending();
    test_chan_en();
    test_oneshot_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
